// File: rtl/rptr_handler.sv
// Read-domain pointer logic for an async FIFO: binary/Gray read pointers
// plus a registered empty flag computed from the post-read pointer.
module rptr_handler #(
  parameter int PTR_WIDTH = 3
) (
  input  logic               rclk,
  input  logic               rrst_n,
  input  logic               r_en,
  input  logic [PTR_WIDTH:0] g_wptr_sync,
  output logic [PTR_WIDTH:0] b_rptr,
  output logic [PTR_WIDTH:0] g_rptr,
  output logic               empty
);

  logic               rd;
  logic [PTR_WIDTH:0] b_next;
  logic [PTR_WIDTH:0] g_next;
  logic               empty_next;

  assign rd         = r_en & ~empty;
  assign b_next     = b_rptr + {{PTR_WIDTH{1'b0}}, rd};
  assign g_next     = (b_next >> 1) ^ b_next;
  // Full-width compare: the wrap bit separates "empty" from "one lap apart".
  assign empty_next = (g_next == g_wptr_sync);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      b_rptr <= '0;
      g_rptr <= '0;
      empty  <= 1'b1;
    end else begin
      b_rptr <= b_next;
      g_rptr <= g_next;
      empty  <= empty_next;
    end
  end

endmodule

// File: tb/tb_rptr_handler.sv
// Randomized + directed bench for rptr_handler against a read/write count model.
module tb_rptr_handler;
  localparam int PW  = 3;
  localparam int W   = PW + 1;
  localparam int MOD = 1 << W;

  logic         rclk;
  logic         rrst_n;
  logic         r_en;
  logic [W-1:0] g_wptr_sync;
  logic [W-1:0] b_rptr;
  logic [W-1:0] g_rptr;
  logic         empty;

  int n_chk  = 0;
  int n_fail = 0;
  int m_rc   = 0;    // reads accepted since reset (unbounded count)
  int m_wc   = 0;    // writes the write side has published
  bit m_empty = 1'b1;

  rptr_handler #(.PTR_WIDTH(PW)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .r_en(r_en), .g_wptr_sync(g_wptr_sync),
    .b_rptr(b_rptr), .g_rptr(g_rptr), .empty(empty)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: apply inputs, advance the model, check just after the edge.
  task automatic step(input bit r, input int wc);
    logic [W-1:0] pg;
    int prc;
    r_en        = r;
    g_wptr_sync = to_gray(W'(wc));
    pg  = g_rptr;
    prc = m_rc;
    if (r && !m_empty) m_rc++;
    m_empty = ((m_rc % MOD) == (wc % MOD));
    @(posedge rclk); #1;
    chk("b_rptr", 32'(b_rptr), 32'(m_rc % MOD));
    chk("g_rptr", 32'(g_rptr), 32'(to_gray(W'(m_rc))));
    chk("empty",  32'(empty),  32'(m_empty));
    chk("g_step", $countones(g_rptr ^ pg), (m_rc != prc) ? 1 : 0);
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    r_en   = 1'b1;
    g_wptr_sync = to_gray(W'(3));
    repeat (3) @(posedge rclk);
    #1;
    chk("rst_b", 32'(b_rptr), 0);
    chk("rst_g", 32'(g_rptr), 0);
    chk("rst_e", 32'(empty), 1);
    m_rc = 0; m_wc = 0; m_empty = 1'b1;
    r_en = 1'b0;
    g_wptr_sync = '0;
    rrst_n = 1'b1;
  endtask

  initial begin
    rrst_n = 1'b1;
    r_en = 1'b0;
    g_wptr_sync = '0;
    #2;
    do_reset();

    // single entry
    m_wc = 1;
    step(0, m_wc);
    step(1, m_wc);
    // reads while empty are ignored
    repeat (3) step(1, m_wc);
    // sequence 2, 3
    m_wc = 2; step(0, m_wc); step(1, m_wc);
    m_wc = 3; step(0, m_wc); step(1, m_wc);

    // burst of four from a fresh reset
    do_reset();
    m_wc = 4;
    repeat (7) step(1, m_wc);
    chk("burst_stop", 32'(b_rptr), 4);

    // wrap: write side stays one ahead, reads requested every cycle
    for (int i = 0; i < 80; i++) begin
      m_wc = m_rc + 1;
      step(1, m_wc);
    end
    chk("wrap_laps", (m_rc >= MOD) ? 1 : 0, 1);

    // random traffic with a mid-run async reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        rrst_n = 1'b0;
        #1;
        chk("async_b", 32'(b_rptr), 0);
        chk("async_g", 32'(g_rptr), 0);
        chk("async_e", 32'(empty), 1);
        @(posedge rclk); #1;
        m_rc = 0; m_wc = 0; m_empty = 1'b1;
        rrst_n = 1'b1;
      end
      if (($urandom % 2 == 1) && (m_wc - m_rc < (1 << PW))) m_wc++;
      step(bit'($urandom % 2), m_wc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
